// File: rtl/passcode_checker.sv
// Passcode entry controller: buffers keypad digits, checks them on '#' against
// a reference code, and handles failure lockout and inactivity timeout.
module passcode_checker #(
    parameter int CODE_LEN       = 4,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int TIMEOUT_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            key_code,
    input  logic                  key_valid,
    input  logic [4*CODE_LEN-1:0] code_ref,
    output logic                  unlock,
    output logic                  fail,
    output logic                  locked_out,
    output logic                  entry_active,
    output logic [3:0]            digit_count
);

    localparam int BUF_W  = 4 * CODE_LEN;
    localparam int FAIL_W = (MAX_FAILS > 1) ? $clog2(MAX_FAILS + 1) : 1;
    localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam int TOUT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [3:0] KEY_STAR = 4'd12;
    localparam logic [3:0] KEY_HASH = 4'd14;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_LOCKOUT
    } state_t;

    state_t              state, state_next;
    logic [BUF_W-1:0]    buffer, buffer_next;
    logic [3:0]          count, count_next;
    logic                overflow, overflow_next;
    logic [FAIL_W-1:0]   fail_cnt, fail_cnt_next;
    logic [TOUT_W-1:0]   idle_timer, idle_timer_next;
    logic [LOCK_W-1:0]   lock_timer, lock_timer_next;
    logic                key_valid_q;
    logic                unlock_next, fail_next;

    logic key_event;
    logic is_digit;
    logic match;

    assign key_event = key_valid && !key_valid_q;
    assign match     = (count == 4'(CODE_LEN)) && !overflow && (buffer == code_ref);

    always_comb begin
        case (key_code)
            4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6,
            4'd8, 4'd9, 4'd10, 4'd13: is_digit = 1'b1;
            default:                  is_digit = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_next      = state;
        buffer_next     = buffer;
        count_next      = count;
        overflow_next   = overflow;
        fail_cnt_next   = fail_cnt;
        idle_timer_next = idle_timer;
        lock_timer_next = lock_timer;
        unlock_next     = 1'b0;
        fail_next       = 1'b0;

        case (state)
            S_IDLE: begin
                if (key_event && is_digit) begin
                    buffer_next     = BUF_W'(key_code);
                    count_next      = 4'd1;
                    overflow_next   = 1'b0;
                    idle_timer_next = '0;
                    state_next      = S_ENTRY;
                end
            end

            S_ENTRY: begin
                if (key_event) begin
                    idle_timer_next = '0;
                    if (is_digit) begin
                        if (count == 4'(CODE_LEN)) begin
                            overflow_next = 1'b1;
                        end else begin
                            buffer_next = (buffer << 4) | BUF_W'(key_code);
                            count_next  = count + 4'd1;
                        end
                    end else if (key_code == KEY_STAR) begin
                        buffer_next   = '0;
                        count_next    = '0;
                        overflow_next = 1'b0;
                        state_next    = S_IDLE;
                    end else if (key_code == KEY_HASH) begin
                        // Verdict is registered here so the pulse lands in the CHECK cycle.
                        unlock_next   = match;
                        fail_next     = !match;
                        fail_cnt_next = match ? '0 : fail_cnt + FAIL_W'(1);
                        state_next    = S_CHECK;
                    end
                end else if (idle_timer == TOUT_W'(TIMEOUT_CYCLES - 1)) begin
                    buffer_next     = '0;
                    count_next      = '0;
                    overflow_next   = 1'b0;
                    idle_timer_next = '0;
                    state_next      = S_IDLE;
                end else begin
                    idle_timer_next = idle_timer + TOUT_W'(1);
                end
            end

            S_CHECK: begin
                buffer_next     = '0;
                count_next      = '0;
                overflow_next   = 1'b0;
                idle_timer_next = '0;
                lock_timer_next = '0;
                state_next      = (fail_cnt == FAIL_W'(MAX_FAILS)) ? S_LOCKOUT : S_IDLE;
            end

            S_LOCKOUT: begin
                if (lock_timer == LOCK_W'(LOCKOUT_CYCLES - 1)) begin
                    lock_timer_next = '0;
                    fail_cnt_next   = '0;
                    state_next      = S_IDLE;
                end else begin
                    lock_timer_next = lock_timer + LOCK_W'(1);
                end
            end

            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values and updates together.
        if (rst) begin
            state       <= S_IDLE;
            buffer      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            fail_cnt    <= '0;
            idle_timer  <= '0;
            lock_timer  <= '0;
            key_valid_q <= 1'b0;
            unlock      <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state       <= state_next;
            buffer      <= buffer_next;
            count       <= count_next;
            overflow    <= overflow_next;
            fail_cnt    <= fail_cnt_next;
            idle_timer  <= idle_timer_next;
            lock_timer  <= lock_timer_next;
            key_valid_q <= key_valid;
            unlock      <= unlock_next;
            fail        <= fail_next;
        end
    end

    assign locked_out   = (state == S_LOCKOUT);
    assign entry_active = (state == S_ENTRY);
    assign digit_count  = count;

endmodule

// File: tb/tb_passcode_checker.sv
// Scoreboard bench for passcode_checker: '#' presses queue the expected verdict
// and its cycle; a monitor pops and compares whenever unlock or fail pulses.
module tb_passcode_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] code_ref = 16'h0124;
    logic        unlock, fail, locked_out, entry_active;
    logic [3:0]  digit_count;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic unl;
        int   at_cyc;
    } exp_t;
    exp_t sb[$];

    passcode_checker #(
        .CODE_LEN(4), .MAX_FAILS(3), .LOCKOUT_CYCLES(50), .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
        .code_ref(code_ref), .unlock(unlock), .fail(fail),
        .locked_out(locked_out), .entry_active(entry_active),
        .digit_count(digit_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the head of the scoreboard in kind and cycle.
    always @(negedge clk) begin
        if (!rst && (unlock || fail)) begin
            checks++;
            if (unlock && fail) begin
                failures++;
                $display("FAIL pulse_both: unlock=1 fail=1 at cycle %0d, required one-hot", cyc);
            end else if (sb.size() == 0) begin
                failures++;
                $display("FAIL pulse_unexpected: unlock=%0b fail=%0b at cycle %0d, required none", unlock, fail, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (unlock !== e.unl || cyc != e.at_cyc) begin
                    failures++;
                    $display("FAIL pulse_verdict: unlock=%0b at cycle %0d, required unlock=%0b at cycle %0d",
                             unlock, cyc, e.unl, e.at_cyc);
                end
            end
        end
    end

    task automatic press(input logic [3:0] c);
        @(negedge clk);
        key_code  = c;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic press_hash(input logic exp_unlock);
        @(negedge clk);
        key_code  = 4'd14;
        key_valid = 1'b1;
        sb.push_back('{exp_unlock, cyc + 1});
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    // Presses the n low nibbles of seq, most significant first.
    task automatic enter(input logic [31:0] seq, input int n);
        for (int i = n - 1; i >= 0; i--) press(seq[4*i +: 4]);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {27'd0, unlock, fail, locked_out, entry_active, |digit_count}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("reset_outputs");
        check("reset_count", {28'd0, digit_count}, 32'd0);
        rst = 1'b0;
    endtask

    int t;

    initial begin
        rst       = 1'b1;
        key_code  = 4'd0;
        key_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("initial_reset");
        rst = 1'b0;

        // 1: correct code unlocks, buffer emptied afterwards
        enter(32'h0124, 4);
        check("t1_count4", {28'd0, digit_count}, 32'd4);
        check("t1_entry", {31'd0, entry_active}, 32'd1);
        press_hash(1'b1);
        @(negedge clk);
        check("t1_count_cleared", {28'd0, digit_count}, 32'd0);
        check("t1_entry_cleared", {31'd0, entry_active}, 32'd0);

        // 2: three wrong codes lock out for 50 cycles; keys ignored meanwhile
        repeat (2) begin
            enter(32'h0125, 4);
            press_hash(1'b0);
            @(negedge clk);
            check("t2_not_locked", {31'd0, locked_out}, 32'd0);
        end
        enter(32'h0125, 4);
        press_hash(1'b0);
        t = cyc;
        wait_until(t + 1);
        check("t2_locked_start", {31'd0, locked_out}, 32'd1);
        enter(32'h0124, 4);
        press(4'd14);
        check("t2_lock_ignores_keys", {27'd0, entry_active, digit_count}, 32'd0);
        wait_until(t + 50);
        check("t2_locked_last", {31'd0, locked_out}, 32'd1);
        wait_until(t + 51);
        check("t2_released", {31'd0, locked_out}, 32'd0);
        enter(32'h0124, 4);
        press_hash(1'b1);

        // 3: overflow, short code, and '*' clear
        enter(32'h01245, 5);
        check("t3_count_saturates", {28'd0, digit_count}, 32'd4);
        press_hash(1'b0);
        enter(32'h01, 2);
        press_hash(1'b0);
        enter(32'h01, 2);
        press(4'd12);
        check("t3_star_clears", {27'd0, entry_active, digit_count}, 32'd0);
        enter(32'h0124, 4);
        press_hash(1'b1);

        // 4: held key gives one event; letters change nothing
        @(negedge clk);
        key_code  = 4'd0;
        key_valid = 1'b1;
        repeat (10) @(negedge clk);
        key_valid = 1'b0;
        check("t4_held_one_digit", {28'd0, digit_count}, 32'd1);
        enter(32'h37BF, 4);
        check("t4_letters_ignored", {28'd0, digit_count}, 32'd1);
        press(4'd12);
        press(4'd3);
        check("t4_letter_in_idle", {31'd0, entry_active}, 32'd0);

        // 5: inactivity timeout after 20 idle cycles, and a late key that keeps entry
        enter(32'h01, 2);
        t = cyc - 1;
        wait_until(t + 20);
        check("t5_entry_before_timeout", {31'd0, entry_active}, 32'd1);
        wait_until(t + 21);
        check("t5_timeout", {27'd0, entry_active, digit_count}, 32'd0);
        enter(32'h01, 2);
        t = cyc - 1;
        wait_until(t + 18);
        press(4'd2);
        wait_until(t + 21);
        check("t5_entry_kept", {27'd0, entry_active, digit_count}, {27'd0, 1'b1, 4'd3});
        press(4'd12);

        // 6: reset mid-entry and mid-lockout restores everything, including fail_cnt
        repeat (2) begin
            enter(32'h0125, 4);
            press_hash(1'b0);
        end
        enter(32'h012, 3);
        check("t6_count3", {28'd0, digit_count}, 32'd3);
        do_reset();
        enter(32'h0125, 4);
        press_hash(1'b0);
        @(negedge clk);
        check("t6_failcnt_cleared", {31'd0, locked_out}, 32'd0);
        repeat (2) begin
            enter(32'h0125, 4);
            press_hash(1'b0);
        end
        @(negedge clk);
        check("t6_locked", {31'd0, locked_out}, 32'd1);
        repeat (5) @(negedge clk);
        do_reset();
        repeat (2) begin
            enter(32'h0125, 4);
            press_hash(1'b0);
        end
        @(negedge clk);
        check("t6_two_fails_no_lock", {31'd0, locked_out}, 32'd0);
        enter(32'h0125, 4);
        press_hash(1'b0);
        @(negedge clk);
        check("t6_third_fail_locks", {31'd0, locked_out}, 32'd1);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
